// File: rtl/kb_div3_pkg.sv
// kb_div3_pkg: shared constants, state type and helpers for the div3/mul3 datapaths
package kb_div3_pkg;
  localparam int NIBBLE_W = 4;
  localparam int REM_MAX = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul3_state_t;
  function automatic int num_nib(input int size);
    return size / NIBBLE_W;
  endfunction
endpackage

// File: rtl/kb_mul3_nibble.sv
// kb_mul3_nibble: combinational 3*nib+cin for one nibble; cout never exceeds 2
module kb_mul3_nibble (
  input  logic [3:0] nib,
  input  logic [1:0] cin,
  output logic [3:0] sum,
  output logic [1:0] cout
);
  logic [5:0] w_t;
  assign w_t = {1'b0, nib, 1'b0} + {2'b00, nib} + {4'b0000, cin};
  assign {cout, sum} = w_t;
endmodule

// File: rtl/kb_mul3_shift_register.sv
// kb_mul3_shift_register: rebuilds dividend = 3*quotient + remainder, one nibble per clock, LSB first
module kb_mul3_shift_register
  import kb_div3_pkg::*;
#(
  parameter int SIZE = 20
) (
  input  logic            sys_clock,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] quotient,
  input  logic [1:0]      reminder,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [SIZE+1:0] dividend
);
  localparam int NUM_NIB = num_nib(SIZE);
  localparam int CW = $clog2(NUM_NIB + 1);
  mul3_state_t     r_state, w_next;
  logic [SIZE-1:0] r_q, r_acc;
  logic [1:0]      r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [SIZE+1:0] r_dividend;
  logic [3:0]      w_sum;
  logic [1:0]      w_cout;
  logic            w_bad, w_last, w_accept;
  kb_mul3_nibble u_nib (.nib(r_q[3:0]), .cin(r_carry), .sum(w_sum), .cout(w_cout));
  assign w_bad    = reminder > 2'(REM_MAX);
  assign w_last   = r_cnt == CW'(NUM_NIB - 1);
  assign w_accept = (r_state == IDLE) && start;
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? (w_bad ? DONE : RUN) : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // The final carry becomes the top two dividend bits on the last nibble
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_q        <= '0;
      r_acc      <= '0;
      r_carry    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_dividend <= '0;
    end else if (w_accept) begin
      r_q     <= quotient;
      r_carry <= reminder;
      r_cnt   <= '0;
      r_err   <= w_bad;
      if (w_bad) r_dividend <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= {w_sum, r_acc[SIZE-1:4]};
      r_q     <= r_q >> NIBBLE_W;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_dividend <= {w_cout, w_sum, r_acc[SIZE-1:4]};
    end
  end
  assign busy     = r_state == RUN;
  assign done     = r_state == DONE;
  assign err      = r_err;
  assign dividend = r_dividend;
endmodule

// File: tb/tb_kb_mul3_shift_register.sv
// tb_kb_mul3_shift_register: scoreboard bench; issuer queues expected results, monitor checks each done
module tb_kb_mul3_shift_register;
  logic        sys_clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] quotient = '0;
  logic [1:0]  reminder = '0;
  logic        busy, done, err;
  logic [21:0] dividend;
  typedef struct packed {
    logic [21:0] d;
    logic        e;
    int          cyc;
    int          nbusy;
  } exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0, cyc = 0, busy_run = 0;
  kb_mul3_shift_register #(.SIZE(20)) dut (
    .sys_clock(sys_clock), .reset(reset), .start(start), .quotient(quotient),
    .reminder(reminder), .busy(busy), .done(done), .err(err), .dividend(dividend)
  );
  always #5 sys_clock = ~sys_clock;
  initial forever begin
    @(posedge sys_clock);
    cyc++;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  task automatic wait_idle;
    int k = 0;
    while ((busy || done) && k < 50) begin
      @(posedge sys_clock); #1;
      k++;
    end
    if (k >= 50) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy=%0b done=%0b", busy, done);
    end
  endtask
  task automatic go(input logic [19:0] q, input logic [1:0] r, input logic [21:0] xd, input bit push);
    exp_t e;
    wait_idle();
    start = 1'b1; quotient = q; reminder = r;
    if (push) begin
      e.d = xd;
      e.e = (r == 2'b11);
      e.cyc = cyc + 1 + ((r == 2'b11) ? 0 : 5);
      e.nbusy = (r == 2'b11) ? 0 : 5;
      sbq.push_back(e);
    end
    @(posedge sys_clock); #1;
    start = 1'b0;
  endtask
  initial forever begin
    exp_t e;
    @(negedge sys_clock);
    if (reset) busy_run = 0;
    else begin
      if (busy && done) begin
        tests++; fails++;
        $display("FAIL busy_done_overlap: busy=1 done=1 at cycle %0d", cyc);
      end
      if (busy) busy_run++;
      if (done) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: dividend=%0h at cycle %0d", dividend, cyc);
        end else begin
          e = sbq.pop_front();
          chk("dividend", 32'(dividend), 32'(e.d));
          chk("err", 32'(err), 32'(e.e));
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_run, e.nbusy);
        end
        busy_run = 0;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [19:0] q;
    logic [1:0]  r;
    int k;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dividend", 32'(dividend), 0);
    @(posedge sys_clock); #1;
    reset = 1'b0;
    go(20'h00000, 2'd0, 22'h000000, 1);
    go(20'd5,     2'd2, 22'd17,     1);
    go(20'hFFFFF, 2'd2, 22'h2FFFFF, 1);
    go(20'h12345, 2'd1, 22'h369D0,  1);
    go(20'h12345, 2'b11, 22'h0,     1);
    chk("err_busy_low", 32'(busy), 0);
    @(posedge sys_clock); #1;
    chk("err_hold", 32'(err), 1);
    chk("err_div_zero", 32'(dividend), 0);
    go(20'h00123, 2'd0, 22'h000369, 1);
    @(posedge sys_clock); #1;
    start = 1'b1; quotient = 20'hABCDE; reminder = 2'd1;
    @(posedge sys_clock); #1;
    start = 1'b0;
    wait_idle();
    go(20'h54321, 2'd2, 22'h0, 0);
    @(posedge sys_clock); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_dividend", 32'(dividend), 0);
    @(posedge sys_clock); #1;
    reset = 1'b0;
    go(20'h0000A, 2'd1, 22'd31, 1);
    for (int i = 0; i < 300; i++) begin
      q = 20'($urandom);
      r = 2'($urandom_range(0, 2));
      go(q, r, {2'b00, q} * 22'd3 + {20'd0, r}, 1);
    end
    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      @(posedge sys_clock); #1;
      k++;
    end
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
